// File: rtl/plic_gateway.sv
// PLIC interrupt gateway: per-source IDLE/PENDING/IN_SERVICE tracking
// with edge counting and claim/complete handshake checking.
module plic_gateway #(
  parameter int NUM_SOURCES       = 3,
  parameter int ID_BITWIDTH       = 3,
  parameter int PRIORITY_BITWIDTH = 4,
  parameter int EDGE_CNT_BITWIDTH = 2
) (
  input  logic                         ck,
  input  logic                         rst_n,
  input  logic [NUM_SOURCES-1:0]       irq_sources_i,
  input  logic [NUM_SOURCES-1:0]       edge_sensitive_i,
  input  logic [NUM_SOURCES-1:0]
               [PRIORITY_BITWIDTH-1:0] priorities_cfg_i,
  input  logic                         claim_i,
  input  logic [ID_BITWIDTH-1:0]       claim_id_i,
  input  logic                         complete_i,
  input  logic [ID_BITWIDTH-1:0]       complete_id_i,
  output logic [NUM_SOURCES-1:0]       pending_o,
  output logic [NUM_SOURCES-1:0]
               [PRIORITY_BITWIDTH-1:0] priorities_o,
  output logic [NUM_SOURCES-1:0]
               [ID_BITWIDTH-1:0]       identifiers_o,
  output logic                         handshake_error_o
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] PENDING    = 2'd1;
  localparam logic [1:0] IN_SERVICE = 2'd2;

  localparam logic [EDGE_CNT_BITWIDTH-1:0] CNT_MAX = '1;
  localparam logic [EDGE_CNT_BITWIDTH-1:0] CNT_ONE =
    EDGE_CNT_BITWIDTH'(1);

  logic [NUM_SOURCES-1:0][1:0] state_q, state_d;
  logic [NUM_SOURCES-1:0] irq_q;
  logic [NUM_SOURCES-1:0] rise;
  logic [NUM_SOURCES-1:0] claim_hit;
  logic [NUM_SOURCES-1:0] compl_hit;
  logic [NUM_SOURCES-1:0] consume;
  logic [NUM_SOURCES-1:0] is_pend;
  logic [NUM_SOURCES-1:0] is_insvc;
  logic [NUM_SOURCES-1:0]
        [EDGE_CNT_BITWIDTH-1:0] cnt_q, cnt_d;
  logic [NUM_SOURCES-1:0]
        [PRIORITY_BITWIDTH-1:0] prio_q, prio_d;
  logic err_q, err_d;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      irq_q   <= '0;
      cnt_q   <= '0;
      prio_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_sources_i;
      cnt_q   <= cnt_d;
      prio_q  <= prio_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    consume   = '0;
    rise      = irq_sources_i & ~irq_q;
    claim_hit = '0;
    compl_hit = '0;
    is_pend   = '0;
    is_insvc  = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      claim_hit[i] = claim_i &&
        (claim_id_i == ID_BITWIDTH'(i + 1));
      compl_hit[i] = complete_i &&
        (complete_id_i == ID_BITWIDTH'(i + 1));
      is_pend[i]   = state_q[i] == PENDING;
      is_insvc[i]  = state_q[i] == IN_SERVICE;
      unique case (state_q[i])
        IDLE: begin
          if (edge_sensitive_i[i]) begin
            if (rise[i] || cnt_q[i] != '0) begin
              state_d[i] = PENDING;
              consume[i] = 1'b1;
            end
          end else if (irq_sources_i[i]) begin
            state_d[i] = PENDING;
          end
        end
        PENDING:
          if (claim_hit[i]) state_d[i] = IN_SERVICE;
        IN_SERVICE:
          if (compl_hit[i]) state_d[i] = IDLE;
        default: state_d[i] = IDLE;
      endcase
      // a fresh edge that is consumed at once nets to zero
      if (!edge_sensitive_i[i]) begin
        cnt_d[i] = '0;
      end else if (rise[i] && !consume[i]) begin
        if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else if (consume[i] && !rise[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
      end
    end
    err_d = (claim_i && !(|(claim_hit & is_pend))) ||
            (complete_i && !(|(compl_hit & is_insvc)));
  end

  always_comb begin
    for (int i = 0; i < NUM_SOURCES; i++) begin
      pending_o[i]     = state_q[i] == PENDING;
      prio_d[i]        = (state_d[i] == PENDING) ?
                         priorities_cfg_i[i] : '0;
      identifiers_o[i] = ID_BITWIDTH'(i + 1);
    end
    priorities_o      = prio_q;
    handshake_error_o = err_q;
  end

endmodule
